// File: rtl/tlb_walker.sv
// Hardware TLB-miss handler: fetches a two-word PTE over a Wishbone-style read port
// and reloads the TLB with three register writes followed by a TLB write.
module tlb_walker #(
   parameter int         DBW  = 80,
   parameter int         ABW  = 80,
   parameter int         IDXW = 16,
   parameter logic [7:0] TMO  = 8'd255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            miss_i,
   input  logic [ABW-1:0]  miss_vadr_i,
   input  logic [7:0]      asid_i,
   input  logic [ABW-1:0]  ptbase_i,
   output logic            cyc_o,
   output logic            stb_o,
   output logic [ABW-1:0]  adr_o,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic [DBW-1:0]  dat_i,
   output logic            tlb_ld_o,
   output logic [3:0]      tlb_op_o,
   output logic [3:0]      tlb_regno_o,
   output logic [DBW-1:0]  tlb_dat_o,
   input  logic            tlb_idle_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            fault_o,
   output logic [1:0]      fault_code_o,
   output logic [15:0]     walk_cnt_o,
   output logic [15:0]     fault_cnt_o
);

   localparam logic [3:0] TLB_WR      = 4'd3;
   localparam logic [3:0] TLB_WRREG   = 4'd8;
   localparam logic [3:0] TLBVirtPage = 4'd4;
   localparam logic [3:0] TLBPhysPage = 4'd5;
   localparam logic [3:0] TLBASID     = 4'd7;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RD0   = 4'd1,
      S_RD1   = 4'd2,
      S_CHK   = 4'd3,
      S_TVP   = 4'd4,
      S_TPP   = 4'd5,
      S_TAT   = 4'd6,
      S_TWR   = 4'd7,
      S_TWAIT = 4'd8,
      S_FIN   = 4'd9,
      S_FLT   = 4'd10
   } state_t;

   state_t          r_state;
   state_t          r_next;
   logic [ABW-1:0]  r_vadr;
   logic [ABW-1:0]  r_pte_adr;
   logic [7:0]      r_asid;
   logic [DBW-1:0]  r_w0;
   logic [DBW-1:0]  r_w1;
   logic [7:0]      r_tmo;
   logic            r_first;

   logic [ABW-1:0]  w_pte_adr;
   logic [1:0]      w_flt_code;
   state_t          w_issue;
   logic [3:0]      w_cmd_op;
   logic [3:0]      w_cmd_regno;
   logic [DBW-1:0]  w_cmd_dat;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic state_t next_cmd(input state_t s);
      case (s)
         S_TVP:   return S_TPP;
         S_TPP:   return S_TAT;
         S_TAT:   return S_TWR;
         S_TWR:   return S_FIN;
         default: return S_IDLE;
      endcase
   endfunction

   assign w_pte_adr = ptbase_i + ABW'({miss_vadr_i[13+IDXW-1:13], 5'h00});

   // Abort cause for the current cycle; err beats ack, timeout only when ack is absent.
   always_comb begin
      w_flt_code = 2'd0;
      case (r_state)
         S_RD0, S_RD1: begin
            if (err_i) begin
               w_flt_code = 2'd2;
            end else if (!ack_i && (r_tmo == TMO - 8'd1)) begin
               w_flt_code = 2'd3;
            end else begin
               w_flt_code = 2'd0;
            end
         end
         S_CHK: begin
            if (r_w1[2:0] == 3'd0) begin
               w_flt_code = 2'd1;
            end else begin
               w_flt_code = 2'd0;
            end
         end
         default: w_flt_code = 2'd0;
      endcase
   end

   // Payload of the TLB command about to be issued from CHK or TWAIT.
   always_comb begin
      w_issue     = (r_state == S_CHK) ? S_TVP : r_next;
      w_cmd_op    = 4'd0;
      w_cmd_regno = 4'd0;
      w_cmd_dat   = '0;
      case (w_issue)
         S_TVP: begin
            w_cmd_op    = TLB_WRREG;
            w_cmd_regno = TLBVirtPage;
            w_cmd_dat   = DBW'(r_vadr[ABW-1:13]);
         end
         S_TPP: begin
            w_cmd_op    = TLB_WRREG;
            w_cmd_regno = TLBPhysPage;
            w_cmd_dat   = r_w0;
         end
         S_TAT: begin
            w_cmd_op    = TLB_WRREG;
            w_cmd_regno = TLBASID;
            w_cmd_dat   = {r_w1[DBW-1:24], r_asid, r_w1[15:0]};
         end
         S_TWR: begin
            w_cmd_op    = TLB_WR;
            w_cmd_regno = tlb_regno_o;
            w_cmd_dat   = tlb_dat_o;
         end
         default: begin
            w_cmd_op    = 4'd0;
            w_cmd_regno = 4'd0;
            w_cmd_dat   = '0;
         end
      endcase
   end

   // Walk state machine; every output is registered and set on entry to the state that owns it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_next       <= S_IDLE;
         r_vadr       <= '0;
         r_pte_adr    <= '0;
         r_asid       <= 8'd0;
         r_w0         <= '0;
         r_w1         <= '0;
         r_tmo        <= 8'd0;
         r_first      <= 1'b0;
         cyc_o        <= 1'b0;
         stb_o        <= 1'b0;
         adr_o        <= '0;
         tlb_ld_o     <= 1'b0;
         tlb_op_o     <= 4'd0;
         tlb_regno_o  <= 4'd0;
         tlb_dat_o    <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         fault_o      <= 1'b0;
         fault_code_o <= 2'd0;
         walk_cnt_o   <= 16'd0;
         fault_cnt_o  <= 16'd0;
      end else begin
         tlb_ld_o <= 1'b0;
         done_o   <= 1'b0;
         fault_o  <= 1'b0;
         if (w_flt_code != 2'd0) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            fault_o      <= 1'b1;
            fault_code_o <= w_flt_code;
            fault_cnt_o  <= sat_inc(fault_cnt_o);
            r_state      <= S_FLT;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (en_i && miss_i) begin
                     r_vadr    <= miss_vadr_i;
                     r_asid    <= asid_i;
                     r_pte_adr <= w_pte_adr;
                     adr_o     <= w_pte_adr;
                     cyc_o     <= 1'b1;
                     stb_o     <= 1'b1;
                     busy_o    <= 1'b1;
                     r_tmo     <= 8'd0;
                     r_state   <= S_RD0;
                  end else begin
                     busy_o    <= 1'b0;
                  end
               end
               S_RD0: begin
                  if (ack_i) begin
                     r_w0    <= dat_i;
                     adr_o   <= r_pte_adr + ABW'(5'd16);
                     r_tmo   <= 8'd0;
                     r_state <= S_RD1;
                  end else begin
                     r_tmo   <= r_tmo + 8'd1;
                  end
               end
               S_RD1: begin
                  if (ack_i) begin
                     r_w1    <= dat_i;
                     cyc_o   <= 1'b0;
                     stb_o   <= 1'b0;
                     r_state <= S_CHK;
                  end else begin
                     r_tmo   <= r_tmo + 8'd1;
                  end
               end
               S_CHK: begin
                  tlb_ld_o    <= 1'b1;
                  tlb_op_o    <= w_cmd_op;
                  tlb_regno_o <= w_cmd_regno;
                  tlb_dat_o   <= w_cmd_dat;
                  r_state     <= w_issue;
               end
               S_TVP, S_TPP, S_TAT, S_TWR: begin
                  r_first <= 1'b1;
                  r_next  <= next_cmd(r_state);
                  r_state <= S_TWAIT;
               end
               S_TWAIT: begin
                  // The TLB has not yet dropped idle in the cycle right after ld.
                  if (r_first) begin
                     r_first <= 1'b0;
                  end else if (tlb_idle_i) begin
                     if (r_next == S_FIN) begin
                        done_o     <= 1'b1;
                        walk_cnt_o <= sat_inc(walk_cnt_o);
                        r_state    <= S_FIN;
                     end else begin
                        tlb_ld_o    <= 1'b1;
                        tlb_op_o    <= w_cmd_op;
                        tlb_regno_o <= w_cmd_regno;
                        tlb_dat_o   <= w_cmd_dat;
                        r_state     <= w_issue;
                     end
                  end else begin
                     r_first <= 1'b0;
                  end
               end
               S_FIN, S_FLT: begin
                  busy_o  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  cyc_o   <= 1'b0;
                  stb_o   <= 1'b0;
                  busy_o  <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tlb_walker.sv
// Self-checking bench for tlb_walker: bus responder, TLB model and a reference
// model of the walk built from address arithmetic and cycle budgets.
module tb_tlb_walker;

   localparam int         DBW = 80;
   localparam int         ABW = 80;
   localparam logic [7:0] TMO = 8'd255;
   localparam logic [3:0] OP_WR    = 4'd3;
   localparam logic [3:0] OP_WRREG = 4'd8;
   localparam logic [3:0] RG_VP    = 4'd4;
   localparam logic [3:0] RG_PP    = 4'd5;
   localparam logic [3:0] RG_ASID  = 4'd7;

   logic            clk;
   logic            rst_n;
   logic            en_i;
   logic            miss_i;
   logic [ABW-1:0]  miss_vadr_i;
   logic [7:0]      asid_i;
   logic [ABW-1:0]  ptbase_i;
   logic            cyc_o;
   logic            stb_o;
   logic [ABW-1:0]  adr_o;
   logic            ack_i;
   logic            err_i;
   logic [DBW-1:0]  dat_i;
   logic            tlb_ld_o;
   logic [3:0]      tlb_op_o;
   logic [3:0]      tlb_regno_o;
   logic [DBW-1:0]  tlb_dat_o;
   logic            tlb_idle_i;
   logic            busy_o;
   logic            done_o;
   logic            fault_o;
   logic [1:0]      fault_code_o;
   logic [15:0]     walk_cnt_o;
   logic [15:0]     fault_cnt_o;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   logic [79:0] mem [logic [79:0]];
   logic [79:0] rd_q[$];
   logic [87:0] cmd_q[$];
   int          ld_cyc_q[$];

   int          wait_n    = 0;
   bit          err_en    = 1'b0;
   logic [79:0] err_adr   = '0;
   bit          hang      = 1'b0;
   int          tpp_extra = 0;

   int          exp_walk = 0;
   int          exp_fault = 0;
   logic [1:0]  exp_code = 2'd0;

   tlb_walker #(.DBW(DBW), .ABW(ABW), .IDXW(16), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .miss_i(miss_i),
      .miss_vadr_i(miss_vadr_i), .asid_i(asid_i), .ptbase_i(ptbase_i),
      .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o),
      .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
      .tlb_ld_o(tlb_ld_o), .tlb_op_o(tlb_op_o), .tlb_regno_o(tlb_regno_o),
      .tlb_dat_o(tlb_dat_o), .tlb_idle_i(tlb_idle_i),
      .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
      .fault_code_o(fault_code_o), .walk_cnt_o(walk_cnt_o), .fault_cnt_o(fault_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_n <= cyc_n + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: observed no end of run, expected $finish");
      $fatal(1, "watchdog expired");
   end

   // Memory slave: waits wait_n cycles per transfer, then acks or errors.
   initial begin
      bit          in_x;
      int          wc;
      logic [79:0] cur;
      in_x = 1'b0; wc = 0; cur = '0;
      ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
      forever begin
         @(negedge clk);
         ack_i = 1'b0;
         err_i = 1'b0;
         if (rst_n && cyc_o && stb_o) begin
            if (!in_x || adr_o != cur) begin
               in_x = 1'b1; cur = adr_o; wc = 0;
            end
            if (!hang) begin
               if (wc >= wait_n) begin
                  if (err_en && cur == err_adr) begin
                     err_i = 1'b1;
                  end else begin
                     ack_i = 1'b1;
                     dat_i = mem.exists(cur) ? mem[cur] : '0;
                     rd_q.push_back(cur);
                  end
                  in_x = 1'b0;
               end else begin
                  wc++;
               end
            end
         end else begin
            in_x = 1'b0;
         end
      end
   end

   // TLB model: idle drops after each ld and returns on the third cycle after it.
   initial begin
      int lo;
      lo = 0;
      tlb_idle_i = 1'b1;
      forever begin
         @(negedge clk);
         if (tlb_ld_o) begin
            cmd_q.push_back({tlb_op_o, tlb_regno_o, tlb_dat_o});
            ld_cyc_q.push_back(cyc_n);
            lo = (tlb_op_o == OP_WRREG && tlb_regno_o == RG_PP) ? 2 + tpp_extra : 2;
            tlb_idle_i = 1'b0;
         end else if (lo > 0) begin
            lo--;
            tlb_idle_i = 1'b0;
         end else begin
            tlb_idle_i = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_walk(input logic [79:0] vadr, input logic [79:0] ptbase,
                           input logic [7:0] asid, input logic [79:0] w0,
                           input logic [79:0] w1, input int wt, input int err_sel,
                           input bit hg, input int extra, input bit hold);
      logic [79:0] pte;
      logic [79:0] exp_dat[3];
      logic [3:0]  exp_reg[3];
      int          n0, got, exp_off, n_rd, n_cmd;
      bit          was_done, was_fault, cyc_end, exp_done;
      logic [1:0]  code_end;
      pte = ptbase + ((vadr >> 13) % 80'h10000) * 80'd32;
      mem[pte] = w0;
      mem[pte + 80'd16] = w1;
      rd_q.delete(); cmd_q.delete(); ld_cyc_q.delete();
      wait_n = wt; hang = hg; tpp_extra = extra;
      err_en = (err_sel != 0);
      err_adr = (err_sel == 2) ? pte + 80'd16 : pte;
      exp_done = 1'b0; n_cmd = 0;
      if (hg) begin
         exp_off = 1 + int'(TMO); n_rd = 0; exp_code = 2'd3;
      end else if (err_sel == 1) begin
         exp_off = 2 + wt; n_rd = 0; exp_code = 2'd2;
      end else if (err_sel == 2) begin
         exp_off = 3 + 2 * wt; n_rd = 1; exp_code = 2'd2;
      end else if (w1[2:0] == 3'd0) begin
         exp_off = 4 + 2 * wt; n_rd = 2; exp_code = 2'd1;
      end else begin
         exp_off = 20 + 2 * wt + extra; n_rd = 2; n_cmd = 4; exp_done = 1'b1;
      end
      exp_dat[0] = vadr >> 13;
      exp_dat[1] = w0;
      exp_dat[2] = (w1 & ~(80'hFF << 16)) | ({72'd0, asid} << 16);
      exp_reg[0] = RG_VP; exp_reg[1] = RG_PP; exp_reg[2] = RG_ASID;
      if (exp_done) exp_walk++; else exp_fault++;

      @(negedge clk);
      miss_vadr_i = vadr; asid_i = asid; ptbase_i = ptbase; miss_i = 1'b1;
      n0 = cyc_n;
      got = -1; was_done = 1'b0; was_fault = 1'b0; cyc_end = 1'b1; code_end = 2'd0;
      for (int k = 0; k < 400 && got < 0; k++) begin
         @(negedge clk);
         if (!hold) miss_i = 1'b0;
         if (extra > 0 && cmd_q.size() == 2 && !tlb_ld_o)
            chk("tpp_hold", {tlb_op_o, tlb_regno_o, tlb_dat_o}, {OP_WRREG, RG_PP, w0});
         if (done_o || fault_o) begin
            got = cyc_n; was_done = done_o; was_fault = fault_o;
            cyc_end = cyc_o; code_end = fault_code_o;
         end
      end
      miss_i = 1'b0;
      chk("end_cycle", got - n0, exp_off);
      chk("outcome", {was_done, was_fault}, exp_done ? 2'b10 : 2'b01);
      chk("fault_code", code_end, exp_code);
      if (!exp_done) chk("bus_released", cyc_end, 1'b0);
      chk("rd_count", rd_q.size(), n_rd);
      for (int i = 0; i < n_rd && i < rd_q.size(); i++)
         chk("rd_adr", rd_q[i], pte + 80'd16 * i);
      chk("ld_count", cmd_q.size(), n_cmd);
      for (int i = 0; i < n_cmd && i < cmd_q.size(); i++) begin
         chk("ld_cycle", ld_cyc_q[i] - n0, 4 + 2 * wt + 4 * i + ((i > 1) ? extra : 0));
         if (i < 3) begin
            chk("ld_cmd", cmd_q[i], {OP_WRREG, exp_reg[i], exp_dat[i]});
         end else begin
            chk("ld_op_wr", cmd_q[i][87:84], OP_WR);
         end
      end
      @(negedge clk);
      chk("busy_after", busy_o, 1'b0);
      chk("walk_cnt", walk_cnt_o, exp_walk);
      chk("fault_cnt", fault_cnt_o, exp_fault);
   endtask

   initial begin
      logic [79:0] v, pb, a0, a1, pte;
      rst_n = 1'b0; en_i = 1'b1; miss_i = 1'b0;
      miss_vadr_i = '0; asid_i = 8'd0; ptbase_i = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", {cyc_o, stb_o, tlb_ld_o, busy_o, done_o, fault_o, fault_code_o,
                          walk_cnt_o, fault_cnt_o}, 88'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Enable low: misses are ignored.
      en_i = 1'b0; miss_i = 1'b1; rd_q.delete();
      repeat (6) @(negedge clk);
      chk("en_low_busy", busy_o, 1'b0);
      chk("en_low_reads", rd_q.size(), 0);
      miss_i = 1'b0; en_i = 1'b1;
      @(negedge clk);

      run_walk(80'h6000, 80'h1000, 8'h5A, 80'h0ABC_DE00, 80'h1234_5607, 0, 0, 0, 0, 0);
      run_walk(80'h2_4000, 80'h8000, 8'h11, 80'h7777, 80'hFFFF_FFF8, 0, 0, 0, 0, 0);
      run_walk(80'hA000, 80'h3000, 8'h22, 80'h1, 80'h3, 0, 2, 0, 0, 0);
      run_walk(80'hC000, 80'h4000, 8'h33, 80'h2, 80'h5, 0, 0, 1, 0, 0);
      hang = 1'b0;
      run_walk(80'hE000, 80'h5000, 8'h44, 80'hBEEF, 80'h00FF_0001, 1, 0, 0, 8, 0);

      for (int i = 0; i < 8; i++) begin
         v  = {16'($urandom()), $urandom(), $urandom()};
         pb = {16'($urandom()), $urandom(), $urandom()};
         a0 = {16'($urandom()), $urandom(), $urandom()};
         a1 = {16'($urandom()), $urandom(), $urandom()};
         a1[2:0] = (i % 4 == 3) ? 3'd0 : 3'($urandom_range(1, 7));
         run_walk(v, pb, 8'($urandom()), a0, a1, $urandom_range(0, 3),
                  (i == 2) ? $urandom_range(1, 2) : 0, 0, 0, 0);
      end

      // Reset while the walker waits on the TLB after the first ld.
      v = 80'h1_2000; pb = 80'h9000;
      pte = pb + ((v >> 13) % 80'h10000) * 80'd32;
      mem[pte] = 80'h55; mem[pte + 80'd16] = 80'h7;
      rd_q.delete(); cmd_q.delete(); ld_cyc_q.delete();
      wait_n = 0; err_en = 1'b0; tpp_extra = 0;
      @(negedge clk);
      miss_vadr_i = v; ptbase_i = pb; asid_i = 8'h66; miss_i = 1'b1;
      @(negedge clk);
      miss_i = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (cmd_q.size() >= 1 && !tlb_ld_o) break;
      end
      chk("twait_reached", cmd_q.size(), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl", {cyc_o, stb_o, tlb_ld_o, busy_o, done_o, fault_o, fault_code_o,
                       walk_cnt_o, fault_cnt_o}, 88'd0);
      chk("rst_data", {tlb_op_o, tlb_regno_o, tlb_dat_o}, 88'd0);
      chk("rst_adr", adr_o, 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_walk = 0; exp_fault = 0; exp_code = 2'd0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", busy_o, 1'b0);
      run_walk(v, pb, 8'h66, 80'h55, 80'h7, 0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
